// File: rtl/xpb_pkg.sv
// Shared constants and state encoding for the xpb table writer.
// Imported by the table generator top level.
package xpb_pkg;

    localparam int DIGIT_BITS_DEF = 5;
    localparam int TBL_DEPTH_DEF  = 1 << DIGIT_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        POW,
        FILL,
        DONE
    } state_e;

endpackage

// File: rtl/xpb_table_gen_mod_add_sub.sv
// Combinational (a + b) mod n for operands already reduced below n.
// A single conditional subtract is enough because a + b < 2n.
module mod_add_sub #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] r_o
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] n_ext;
    logic           ge;

    assign t     = {1'b0, a_i} + {1'b0, b_i};
    assign n_ext = {1'b0, n_i};
    assign ge    = (t >= n_ext);
    assign r_o   = ge ? WIDTH'(t - n_ext) : t[WIDTH-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime xpb table writer: B = 2^s mod N, then entries j*B mod N.
// One shared modular adder serves both the doubling and the fill phase.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int WIDTH      = 1024,
    parameter int DIGIT_BITS = DIGIT_BITS_DEF,
    parameter int SHIFT_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wr_en,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    localparam logic [DIGIT_BITS-1:0] LAST_K = {DIGIT_BITS{1'b1}};

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      n_q, n_d;
    logic [SHIFT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      run_q, run_d;
    logic [DIGIT_BITS-1:0] k_q, k_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  wr_en_q, wr_en_d;
    logic [DIGIT_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]      wr_data_q, wr_data_d;

    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_r;

    // Doubling adds acc to itself; filling adds acc to the running entry.
    assign add_a = (state_q == POW) ? acc_q : run_q;

    mod_add_sub #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i (add_a),
        .b_i (acc_q),
        .n_i (n_q),
        .r_o (add_r)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            run_q     <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            run_q     <= run_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Phase sequencing: zero modulus skips straight to completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (modulus == '0)
                        state_d = DONE;
                    else if (shift == '0)
                        state_d = FILL;
                    else
                        state_d = POW;
                end
            end
            POW: begin
                if (cnt_q == SHIFT_W'(1))
                    state_d = FILL;
            end
            FILL: begin
                if (k_q == LAST_K)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates and next values of the registered outputs.
    always_comb begin
        n_d       = n_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        run_d     = run_q;
        k_d       = k_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d    = modulus;
                    cnt_d  = shift;
                    acc_d  = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                    run_d  = '0;
                    k_d    = '0;
                    busy_d = 1'b1;
                end
            end
            POW: begin
                acc_d = add_r;
                cnt_d = cnt_q - SHIFT_W'(1);
            end
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = k_q;
                wr_data_d = run_q;
                run_d     = add_r;
                if (k_q != LAST_K)
                    k_d = k_q + DIGIT_BITS'(1);
            end
            DONE: begin
                done_d = 1'b1;
                err_d  = (n_q == '0);
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: wide-integer reference model plus
// hand-computed anchors for small moduli.
module tb_xpb_table_gen;

    localparam int W = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  modulus = '0;
    logic [10:0]   shift = '0;
    logic          busy, done, err, wr_en;
    logic [4:0]    wr_addr;
    logic [W-1:0]  wr_data;

    int checks = 0;
    int errors = 0;
    int beat;
    int nwr;
    logic [W-1:0] exp_tbl [32];
    logic [W-1:0] mem [32];

    xpb_table_gen #(
        .WIDTH      (W),
        .DIGIT_BITS (5),
        .SHIFT_W    (11)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .modulus (modulus),
        .shift   (shift),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (low 192 bits)",
                     nm, act[191:0], req[191:0]);
        end
    endtask

    // j * (2^s mod n) mod n using plain wide arithmetic.
    function automatic logic [W-1:0] model_entry(input logic [W-1:0] n,
                                                 input int s, input int j);
        logic [2111:0] p;
        logic [2111:0] nn;
        nn = {1088'd0, n};
        p  = 2112'(1) << s;
        p  = p % nn;
        p  = p * j;
        p  = p % nn;
        return p[W-1:0];
    endfunction

    // Compare process: every write against the model table.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            chk("busy_during_wr", busy, 1);
            chk("wr_in_range", beat < 32, 1);
            if (beat < 32) begin
                chk("wr_addr", wr_addr, beat);
                chk("wr_data", wr_data, exp_tbl[beat]);
            end
            mem[wr_addr] = wr_data;
            beat++;
            nwr++;
        end
        if (rst_n && done)
            chk("wr_en_at_done", wr_en, 0);
    end

    task automatic setup_job(input logic [W-1:0] n, input int s);
        for (int j = 0; j < 32; j++) begin
            exp_tbl[j] = (n == '0) ? '0 : model_entry(n, s, j);
            mem[j] = '1;
        end
        beat = 0;
        nwr  = 0;
    endtask

    task automatic run_job(input logic [W-1:0] n, input int s,
                           input bit repulse);
        int cyc;
        int lat;
        setup_job(n, s);
        @(negedge clk);
        modulus = n;
        shift   = s[10:0];
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_on_accept", busy, 1);
        cyc = 0;
        while (!done && cyc < 4000) begin
            if (repulse && (cyc == 1 || cyc == s + 8)) begin
                modulus = n + 6;
                shift   = 11'(s + 3);
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        lat = (n == '0) ? 1 : s + 33;
        chk("latency", cyc, lat);
        chk("err", err, (n == '0));
        chk("busy_at_done", busy, 0);
        chk("wr_en_at_done", wr_en, 0);
        chk("write_count", nwr, (n == '0) ? 0 : 32);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("err_one_cycle", err, 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_wr_addr"}, wr_addr, 0);
        chk({nm, "_wr_data"}, wr_data, 0);
    endtask

    logic [W-1:0] prod_n;
    logic [W-1:0] max_n;

    initial begin
        prod_n = {8{128'hC90F_DAA2_2168_C234_C4C6_628B_80DC_1CD1}};
        prod_n[0] = 1'b1;
        max_n = '1;

        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // N=13, s=4: B=3
        run_job(W'(13), 4, 1'b0);
        chk("t1_e1", mem[1], 3);
        chk("t1_e4", mem[4], 12);
        chk("t1_e5", mem[5], 2);
        chk("t1_e13", mem[13], 0);
        chk("t1_e31", mem[31], 2);

        // N=13, s=0: B=1
        run_job(W'(13), 0, 1'b0);
        chk("t2_e12", mem[12], 12);
        chk("t2_e13", mem[13], 0);
        chk("t2_e31", mem[31], 5);

        // N=1 gives an all-zero table; N=0 flags an error
        run_job(W'(1), 9, 1'b0);
        chk("t3_e31", mem[31], 0);
        chk("t3_e7", mem[7], 0);
        run_job('0, 5, 1'b0);

        // wide production-style modulus
        run_job(prod_n, 750, 1'b0);
        chk("t4_e0", mem[0], 0);

        // largest modulus and shift exercise the carry path
        run_job(max_n, 2047, 1'b0);
        chk("t4b_e0", mem[0], 0);

        // start re-pulsed in POW and FILL is ignored
        run_job(W'(13), 4, 1'b1);
        chk("t5_e13", mem[13], 0);
        chk("t5_e31", mem[31], 2);

        // reset at fill beat 10, then a clean job
        begin
            int cyc;
            setup_job(W'(13), 4);
            @(negedge clk);
            modulus = W'(13);
            shift   = 11'd4;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc = 0;
            while (cyc < 4 + 11) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("t6_beat10_addr", wr_addr, 10);
            rst_n = 1'b0;
            #1;
            chk_all_zero("t6_midreset");
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("t6_no_done", done, 0);
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
        run_job(W'(13), 4, 1'b0);
        chk("t6_e5", mem[5], 2);
        chk("t6_e31", mem[31], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
